// File: rtl/sd_resp_rx.sv
// sd_resp_rx: SD CMD-line response receiver.
// Captures 48/136-bit responses, checks CRC7 and framing.
module sd_resp_rx #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         sd_clk,
  input  logic         reset,
  input  logic         start,
  input  logic         long_resp,
  input  logic         check_crc,
  input  logic         sd_cmd,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic         crc_err,
  output logic         frame_err,
  output logic [119:0] resp
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    RECV,
    FINISH
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t       state;
  logic         lng;
  logic         chk;
  logic         pend;
  logic [7:0]   cnt;
  logic [7:0]   tcnt;
  logic [6:0]   crc;
  logic [134:0] sr;

  logic         feed;
  logic [6:0]   crc_base;
  logic         tbit;
  logic [119:0] resp_nxt;

  function automatic logic [6:0] crc_step(
    input logic [6:0] c,
    input logic       b
  );
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], fb} ^ {3'b000, fb, 3'b000};
  endfunction

  // CRC coverage window and the header-skip restart for R2
  always_comb begin
    feed     = (cnt >= 8'd8) && (!lng || cnt <= 8'd127);
    crc_base = (lng && cnt == 8'd127) ? 7'd0 : crc;
    tbit     = lng ? sr[134] : sr[46];
    resp_nxt = lng ? sr[127:8] : {82'd0, sr[45:8]};
  end

  // Receive FSM; outputs registered alongside state
  always_ff @(posedge sd_clk) begin
    if (reset) begin
      state     <= IDLE;
      lng       <= 1'b0;
      chk       <= 1'b0;
      pend      <= 1'b0;
      cnt       <= 8'd0;
      tcnt      <= 8'd0;
      crc       <= 7'd0;
      sr        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      crc_err   <= 1'b0;
      frame_err <= 1'b0;
      resp      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            lng       <= long_resp;
            chk       <= check_crc;
            pend      <= 1'b0;
            tcnt      <= 8'd0;
            crc       <= 7'd0;
            sr        <= '0;
            busy      <= 1'b1;
            timeout   <= 1'b0;
            crc_err   <= 1'b0;
            frame_err <= 1'b0;
            resp      <= '0;
            state     <= WAIT_START;
          end
        end
        WAIT_START: begin
          if (!sd_cmd) begin
            cnt   <= lng ? 8'd134 : 8'd46;
            crc   <= crc_step(7'd0, 1'b0);
            state <= RECV;
          end else if (tcnt == TO_LAST) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= FINISH;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        RECV: begin
          if (pend) begin
            pend      <= 1'b0;
            done      <= 1'b1;
            resp      <= resp_nxt;
            crc_err   <= chk && (crc != sr[7:1]);
            frame_err <= tbit | ~sr[0];
            state     <= FINISH;
          end else begin
            sr <= {sr[133:0], sd_cmd};
            if (feed) begin
              crc <= crc_step(crc_base, sd_cmd);
            end
            if (cnt == 8'd0) begin
              pend <= 1'b1;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_resp_rx.sv
// tb_sd_resp_rx: randomized self-checking bench for sd_resp_rx.
// Reference model builds tokens and CRC7 by polynomial division.
module tb_sd_resp_rx;

  localparam int TO = 64;

  logic         sd_clk = 1'b0;
  logic         reset;
  logic         start;
  logic         long_resp;
  logic         check_crc;
  logic         sd_cmd;
  logic         busy;
  logic         done;
  logic         timeout;
  logic         crc_err;
  logic         frame_err;
  logic [119:0] resp;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  sd_resp_rx #(.TIMEOUT(TO)) dut (
    .sd_clk    (sd_clk),
    .reset     (reset),
    .start     (start),
    .long_resp (long_resp),
    .check_crc (check_crc),
    .sd_cmd    (sd_cmd),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .crc_err   (crc_err),
    .frame_err (frame_err),
    .resp      (resp)
  );

  always #5 sd_clk = ~sd_clk;

  always @(posedge sd_clk) cyc <= cyc + 1;

  function automatic logic [6:0] crc_model(
    input logic [135:0] tok,
    input int           hi
  );
    logic [142:0] w;
    int n;
    w = '0;
    n = hi - 7;
    for (int k = 0; k < n; k++) w[k+7] = tok[k+8];
    for (int i = n + 6; i >= 7; i--)
      if (w[i]) w[i -: 8] = w[i -: 8] ^ 8'h89;
    return w[6:0];
  endfunction

  function automatic logic [135:0] mk_short(
    input logic [5:0]  idx,
    input logic [31:0] arg
  );
    logic [135:0] t;
    t = '0;
    t[47:0] = {2'b00, idx, arg, 7'd0, 1'b1};
    t[7:1] = crc_model(t, 47);
    return t;
  endfunction

  function automatic logic [135:0] mk_long(input logic [119:0] p);
    logic [135:0] t;
    t = {8'h3F, p, 7'd0, 1'b1};
    t[7:1] = crc_model(t, 127);
    return t;
  endfunction

  function automatic logic [119:0] m_resp(
    input logic [135:0] t,
    input logic         lng
  );
    return lng ? t[127:8] : {82'd0, t[45:8]};
  endfunction

  function automatic logic m_crc(
    input logic [135:0] t,
    input logic         lng,
    input logic         chk
  );
    return chk && (crc_model(t, lng ? 127 : 47) != t[7:1]);
  endfunction

  function automatic logic m_frame(
    input logic [135:0] t,
    input logic         lng
  );
    return (lng ? t[134] : t[46]) | ~t[0];
  endfunction

  task automatic run_resp(
    input  logic         lng,
    input  logic         chk,
    input  logic [135:0] tok,
    input  int           idle,
    output int           lat,
    output logic         ok
  );
    int es;
    int len;
    len = lng ? 136 : 48;
    es = 0;
    @(negedge sd_clk);
    start = 1'b1;
    long_resp = lng;
    check_crc = chk;
    sd_cmd = 1'b1;
    @(negedge sd_clk);
    start = 1'b0;
    long_resp = ~lng;
    check_crc = ~chk;
    for (int i = 0; i < idle; i++) begin
      sd_cmd = 1'b1;
      @(negedge sd_clk);
    end
    for (int i = len - 1; i >= 0; i--) begin
      sd_cmd = tok[i];
      @(negedge sd_clk);
      if (i == len - 1) es = cyc;
    end
    sd_cmd = 1'b1;
    ok = 1'b0;
    lat = -1;
    for (int k = 0; k < 8 && !ok; k++) begin
      if (done) begin
        ok = 1'b1;
        lat = cyc - es;
      end else begin
        @(negedge sd_clk);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge sd_clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done got=%b exp=0", done);
    end
    checks++;
    if ({timeout, crc_err, frame_err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b%b%b exp=000",
               timeout, crc_err, frame_err);
    end
    checks++;
    if (resp !== 120'd0) begin
      failures++;
      $display("FAIL reset_resp got=%h exp=0", resp);
    end
    reset = 1'b0;
  endtask

  task automatic test_short();
    logic [135:0] t;
    int lat;
    logic ok;
    t = mk_short(6'd8, 32'h000001AA);
    run_resp(1'b0, 1'b1, t, 5, lat, ok);
    checks++;
    if (!ok || lat != 48) begin
      failures++;
      $display("FAIL r7_latency got=%0d ok=%b exp=48", lat, ok);
    end
    checks++;
    if (resp !== {82'd0, 6'd8, 32'h000001AA}) begin
      failures++;
      $display("FAIL r7_resp got=%h", resp);
    end
    checks++;
    if ({timeout, crc_err, frame_err} !== 3'b000) begin
      failures++;
      $display("FAIL r7_flags got=%b%b%b exp=000",
               timeout, crc_err, frame_err);
    end
    @(negedge sd_clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL r7_pulse done=%b busy=%b exp=0 0", done, busy);
    end
  endtask

  task automatic test_errors();
    logic [135:0] t;
    int lat;
    logic ok;
    t = mk_short(6'd8, 32'h000001AA);
    t[3] = ~t[3];
    run_resp(1'b0, 1'b1, t, 3, lat, ok);
    checks++;
    if (!ok || crc_err !== 1'b1 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL crc_flip ok=%b crc=%b frame=%b exp=1 0",
               ok, crc_err, frame_err);
    end
    t = mk_short(6'd8, 32'h000001AA);
    t[0] = 1'b0;
    run_resp(1'b0, 1'b1, t, 3, lat, ok);
    checks++;
    if (!ok || frame_err !== 1'b1 || crc_err !== 1'b0) begin
      failures++;
      $display("FAIL end_bit ok=%b frame=%b crc=%b exp=1 0",
               ok, frame_err, crc_err);
    end
  endtask

  task automatic test_r3();
    logic [135:0] t;
    int lat;
    logic ok;
    t = '0;
    t[47:0] = 48'h3F_80FF8000_FF;
    run_resp(1'b0, 1'b0, t, 2, lat, ok);
    checks++;
    if (!ok || resp !== {82'd0, 6'h3F, 32'h80FF8000}) begin
      failures++;
      $display("FAIL r3_resp ok=%b got=%h", ok, resp);
    end
    checks++;
    if (crc_err !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL r3_flags crc=%b frame=%b exp=0 0",
               crc_err, frame_err);
    end
  endtask

  task automatic test_r2();
    logic [135:0] t;
    logic [119:0] p;
    int lat;
    logic ok;
    p = 120'h0123_4567_89AB_CDEF_0011_2233_4455_66;
    t = mk_long(p);
    run_resp(1'b1, 1'b1, t, 4, lat, ok);
    checks++;
    if (!ok || lat != 136) begin
      failures++;
      $display("FAIL r2_latency got=%0d ok=%b exp=136", lat, ok);
    end
    checks++;
    if (resp !== p) begin
      failures++;
      $display("FAIL r2_resp got=%h exp=%h", resp, p);
    end
    checks++;
    if ({timeout, crc_err, frame_err} !== 3'b000) begin
      failures++;
      $display("FAIL r2_flags got=%b%b%b exp=000",
               timeout, crc_err, frame_err);
    end
  endtask

  task automatic test_timeout();
    int e0;
    int lat;
    logic ok;
    @(negedge sd_clk);
    start = 1'b1;
    long_resp = 1'b0;
    check_crc = 1'b1;
    sd_cmd = 1'b1;
    @(negedge sd_clk);
    start = 1'b0;
    e0 = cyc;
    checks++;
    if (busy !== 1'b1 || resp !== 120'd0) begin
      failures++;
      $display("FAIL arm_busy busy=%b resp=%h exp=1 0", busy, resp);
    end
    ok = 1'b0;
    lat = -1;
    for (int k = 0; k < TO + 16 && !ok; k++) begin
      @(negedge sd_clk);
      if (done) begin
        ok = 1'b1;
        lat = cyc - e0;
      end
    end
    checks++;
    if (!ok || lat != TO) begin
      failures++;
      $display("FAIL to_latency got=%0d ok=%b exp=%0d", lat, ok, TO);
    end
    checks++;
    if (timeout !== 1'b1 || crc_err !== 1'b0 || resp !== 120'd0) begin
      failures++;
      $display("FAIL to_flags to=%b crc=%b resp=%h exp=1 0 0",
               timeout, crc_err, resp);
    end
  endtask

  task automatic test_timeout_edge();
    logic [135:0] t;
    logic [31:0] a;
    int lat;
    logic ok;
    a = $urandom;
    t = mk_short(6'd17, a);
    run_resp(1'b0, 1'b1, t, TO - 1, lat, ok);
    checks++;
    if (!ok || lat != 48 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL to_edge ok=%b lat=%0d to=%b exp=1 48 0",
               ok, lat, timeout);
    end
    checks++;
    if (resp !== {82'd0, 6'd17, a} || crc_err !== 1'b0) begin
      failures++;
      $display("FAIL to_edge_resp got=%h crc=%b", resp, crc_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [135:0] t;
    int lat;
    logic ok;
    t = mk_short(6'd3, 32'hDEADBEEF);
    @(negedge sd_clk);
    start = 1'b1;
    long_resp = 1'b0;
    check_crc = 1'b1;
    sd_cmd = 1'b1;
    @(negedge sd_clk);
    start = 1'b0;
    @(negedge sd_clk);
    for (int i = 47; i > 20; i--) begin
      sd_cmd = t[i];
      @(negedge sd_clk);
    end
    sd_cmd = t[20];
    reset = 1'b1;
    @(negedge sd_clk);
    reset = 1'b0;
    sd_cmd = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 ||
        {timeout, crc_err, frame_err} !== 3'b000 ||
        resp !== 120'd0) begin
      failures++;
      $display("FAIL mid_reset busy=%b done=%b flags=%b%b%b resp=%h",
               busy, done, timeout, crc_err, frame_err, resp);
    end
    run_resp(1'b0, 1'b1, t, 2, lat, ok);
    checks++;
    if (!ok || lat != 48 || resp !== {82'd0, 6'd3, 32'hDEADBEEF} ||
        crc_err !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL post_reset ok=%b lat=%0d resp=%h crc=%b frm=%b",
               ok, lat, resp, crc_err, frame_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [135:0] t;
    int lat;
    logic ok;
    t = mk_short(6'd5, 32'h12345678);
    run_resp(1'b0, 1'b1, t, 1, lat, ok);
    start = 1'b1;
    long_resp = 1'b0;
    check_crc = 1'b1;
    @(negedge sd_clk);
    checks++;
    if (busy !== 1'b0 || resp !== {82'd0, 6'd5, 32'h12345678}) begin
      failures++;
      $display("FAIL b2b_ignored busy=%b resp=%h exp=0", busy, resp);
    end
    @(negedge sd_clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || resp !== 120'd0) begin
      failures++;
      $display("FAIL b2b_accept busy=%b resp=%h exp=1 0", busy, resp);
    end
    ok = 1'b0;
    for (int k = 0; k < TO + 16 && !ok; k++) begin
      @(negedge sd_clk);
      if (done) ok = 1'b1;
    end
    checks++;
    if (!ok || timeout !== 1'b1) begin
      failures++;
      $display("FAIL b2b_timeout ok=%b to=%b exp=1 1", ok, timeout);
    end
  endtask

  task automatic test_random();
    logic [135:0] t;
    logic [127:0] r;
    logic lng;
    logic chk;
    int err;
    int pos;
    int lat;
    logic ok;
    for (int it = 0; it < 24; it++) begin
      lng = 1'($urandom_range(0, 1));
      chk = 1'($urandom_range(0, 1));
      r = {$urandom, $urandom, $urandom, $urandom};
      t = lng ? mk_long(r[119:0]) : mk_short(r[37:32], r[31:0]);
      err = $urandom_range(0, 3);
      if (err == 1) begin
        pos = $urandom_range(1, 7);
        t[pos] = ~t[pos];
      end else if (err == 2) begin
        t[0] = 1'b0;
      end else if (err == 3) begin
        if (lng) t[134] = 1'b1;
        else t[46] = 1'b1;
      end
      run_resp(lng, chk, t, $urandom_range(0, 40), lat, ok);
      checks++;
      if (!ok || lat != (lng ? 136 : 48)) begin
        failures++;
        $display("FAIL rnd%0d_lat ok=%b got=%0d lng=%b", it, ok, lat, lng);
      end
      checks++;
      if (resp !== m_resp(t, lng)) begin
        failures++;
        $display("FAIL rnd%0d_resp got=%h exp=%h",
                 it, resp, m_resp(t, lng));
      end
      checks++;
      if (crc_err !== m_crc(t, lng, chk) ||
          frame_err !== m_frame(t, lng) || timeout !== 1'b0) begin
        failures++;
        $display("FAIL rnd%0d_flags crc=%b/%b frm=%b/%b to=%b err=%0d",
                 it, crc_err, m_crc(t, lng, chk),
                 frame_err, m_frame(t, lng), timeout, err);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    long_resp = 1'b0;
    check_crc = 1'b0;
    sd_cmd = 1'b1;
    test_reset();
    test_short();
    test_errors();
    test_r3();
    test_r2();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge sd_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_resp_rx.md
# sd_resp_rx

Command-line response receiver for the SD host controller. It runs on `sd_clk` and sits directly downstream of the command sender. Once the sender reports a command finished, the receiver is armed, waits for the card's start bit on the CMD line and shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response. It then checks CRC7, the transmission bit and the end bit, and presents the payload with a one-cycle `done` pulse plus status flags.

## Interface
- `TIMEOUT`, 64: maximum sd_clk samples to wait for a start bit after arming (NCR limit); legal range 2..255.
- `sd_clk`  in  1  single clock. All state updates and CMD-line sampling on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  arm request. Honoured only in IDLE; ignored otherwise.
- `long_resp`  in  1  1 = expect 136-bit R2. Captured when `start` is accepted.
- `check_crc`  in  1  1 = verify CRC7 (0 for R3). Captured when `start` is accepted.
- `sd_cmd`  in  1  CMD line from the card; idles high.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `timeout`  out  1  no start bit seen within `TIMEOUT` samples.
- `crc_err`  out  1  received CRC7 differs from the computed CRC7.
- `frame_err`  out  1  transmission bit ≠ 0 or end bit ≠ 1.
- `resp`  out  120  payload; format in Operation.

## Operation
- FSM states: IDLE, WAIT_START, RECV, FINISH.
- IDLE:
  - On `start`=1: capture `long_resp` and `check_crc`, clear all flags and `resp`, clear the CRC register and timeout counter, go to WAIT_START.
- WAIT_START:
  - Each edge samples `sd_cmd`.
  - 0 = start bit (token bit 47 or 135). Load bit counter with 46 or 134, clear CRC, feed the 0 into CRC, go to RECV.
  - 1 = increment the timeout counter. When the counter reaches `TIMEOUT`, set `timeout`=1 and go to FINISH.
- RECV:
  - Each edge shifts `sd_cmd` into the shift register and decrements the bit counter. Exit after the end bit (counter 0) to FINISH.
  - Transmission bit (token bit 46 or 134): latched; nonzero → `frame_err`.
  - CRC7 (x^7+x^3+1, serial, MSB first):
    - Short response: fed with token bits 47..8, i.e. start and transmission bits included.
    - Long response: fed with token bits 127..8 only, so the R2 header bits 135..128 are excluded. The CRC register is cleared just before bit 127.
  - Token bits 7..1 are the received CRC, compared at the end bit.
  - End bit ≠ 1 → `frame_err`.
- FINISH: `done`=1 for this cycle only, then IDLE. Flags and `resp` hold until the next accepted `start` or `reset`.
- `resp` format:
  - Short response: `resp[37:0]` = token bits 45:8, i.e. `[37:32]` = command index and `[31:0]` = argument. `resp[119:38]` = 0.
  - Long response: `resp[119:0]` = token bits 127:8 (CID/CSD without internal CRC and end bit).
- `crc_err` is forced to 0 when the captured `check_crc`=0, and on timeout.
- Reset at any time, including mid-receive: next state IDLE, and every output returns to its reset value.
- Reset values: `busy`=0, `done`=0, `timeout`=0, `crc_err`=0, `frame_err`=0, `resp`=0.

## Timing
- Arming: `start` sampled high at edge E0 in IDLE → `busy`=1 from E0. The first `sd_cmd` sample is taken at E1.
- Start bit sampled at edge Es → short response: end bit sampled at Es+47. Long response: end bit at Es+135.
- `done` is high during the cycle following the end-bit edge, i.e. from edge Es+48 (short) or Es+136 (long). `busy` falls on the same edge that lowers `done`.
- Timeout: if the samples at E1..E(`TIMEOUT`) are all 1, `done`=1 and `timeout`=1 from edge E(`TIMEOUT`). A start bit at the `TIMEOUT`-th sample itself is accepted.
- Back-to-back operation: `start` asserted in the `done` cycle is ignored. It is accepted on the following edge (IDLE).
- `done`, flags and `resp` are registered; there is no combinational path from `sd_cmd` to any output.

## Test plan
- Short R7 response: arm with `long_resp`=0 and `check_crc`=1. Drive 5 idle-high cycles, then token index 8, argument 0x000001AA, with correct CRC7 from the bench model. Required: `done` exactly 48 cycles after the start-bit edge; `resp[37:0]`={6'd8, 32'h000001AA}; all flags 0.
- Same token with received CRC bit 3 flipped → `crc_err`=1, `frame_err`=0. Repeat with the end bit driven 0 → `frame_err`=1.
- R3 with `check_crc`=0: token 0x3F 80FF8000 FF → `resp[37:0]`={6'h3F, 32'h80FF8000}, `crc_err`=0.
- R2 with `long_resp`=1: 120-bit payload 0x0123_4567_89AB_CDEF_0011_2233_4455_66 with correct CRC7 → `resp` matches; `done` 136 cycles after the start-bit edge; no errors.
- `TIMEOUT`=64 with `sd_cmd` held high → `done` and `timeout` high at edge E64 and `resp`=0. Start bit exactly at sample 64 → accepted, no timeout.
- Reset asserted at RECV bit 20 → next cycle `busy`=0 and all outputs 0. A new `start` then receives a full short response correctly.
